// File: rtl/hedios_uart_pkg.sv
// Shared FSM encoding and baud-timing helpers for the Hedios UART receiver.
package hedios_uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    // Clocks per bit period (integer division).
    function automatic int unsigned calc_cpb(input int unsigned clk_rate,
                                             input int unsigned baud_rate);
        return clk_rate / baud_rate;
    endfunction

    // Offset from the start edge to the middle of the start bit.
    function automatic int unsigned calc_half(input int unsigned clk_rate,
                                              input int unsigned baud_rate);
        return calc_cpb(clk_rate, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/hedios_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 1 (idle line).
module hedios_bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_stages_check
        $error("hedios_bit_sync: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw bit in at the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{1'b1}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hedios_uart_rx.sv
// UART 8N1 receiver with a one-byte holding register and valid/ready handoff.
module hedios_uart_rx
    import hedios_uart_pkg::*;
#(
    parameter int unsigned CLK_RATE  = 100_000_000,
    parameter int unsigned BAUD_RATE = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CPB   = calc_cpb(CLK_RATE, BAUD_RATE);
    localparam int unsigned HALF  = calc_half(CLK_RATE, BAUD_RATE);
    localparam int unsigned TMR_W = $clog2(CPB);

    if (CPB < 8) begin : g_cpb_check
        $error("hedios_uart_rx: CLK_RATE/BAUD_RATE must be at least 8");
    end

    localparam logic [TMR_W-1:0] CPB_LAST  = TMR_W'(CPB - 1);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF - 1);

    logic             rx_s;
    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;
    logic             xfer;
    logic             tmr_wrap;

    hedios_bit_sync #(.STAGES(2)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_line),
        .q   (rx_s)
    );

    // Next-state, bit timing, shift register and holding-register control.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        xfer     = valid_q && out_ready;
        tmr_wrap = (tmr_q == CPB_LAST);

        if (xfer) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    tmr_d   = '0;
                end
            end
            ST_START: begin
                if (tmr_q == HALF_LAST) begin
                    tmr_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_DATA: begin
                if (tmr_wrap) begin
                    tmr_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_STOP: begin
                if (tmr_wrap) begin
                    tmr_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                        if (!valid_q || out_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_WAIT_IDLE;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_hedios_uart_rx.sv
// Randomized bench for hedios_uart_rx against a frame-level reference model.
module tb_hedios_uart_rx;

    localparam int CPB      = 100;
    localparam int HALF     = CPB / 2;
    localparam int SYNC_LAT = 2;
    // Edge index (relative to the edge after which the line drops) at which the stop decision lands.
    localparam int STOP_OFS = SYNC_LAT + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_line;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    hedios_uart_rx #(
        .CLK_RATE  (100_000_000),
        .BAUD_RATE (1_000_000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_line   (rx_line),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         stop_cyc;
        bit         good;
        logic [7:0] data;
    } stop_t;

    stop_t      pend[$];
    int         cyc        = 0;
    bit         m_full     = 1'b0;
    logic [7:0] m_data     = 8'd0;
    bit         m_ferr     = 1'b0;
    bit         m_ovr      = 1'b0;
    bit         m_busy     = 1'b0;
    int         m_xfer_cnt = 0;
    int         f_start    = -10;
    int         f_end      = -10;

    always @(posedge clk) begin
        bit    xf;
        stop_t p;
        cyc++;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        if (rst) begin
            pend.delete();
            m_full = 1'b0;
            m_data = 8'd0;
            f_end  = -10;
        end else begin
            xf = m_full && out_ready;
            if (xf) m_xfer_cnt++;
            if (pend.size() > 0 && pend[0].stop_cyc == cyc) begin
                p = pend.pop_front();
                if (p.good) begin
                    if (!m_full || out_ready) begin
                        m_full = 1'b1;
                        m_data = p.data;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else begin
                    m_ferr = 1'b1;
                    if (xf) m_full = 1'b0;
                end
            end else if (xf) begin
                m_full = 1'b0;
            end
        end
        m_busy = (cyc >= f_start + SYNC_LAT + 1) && (cyc <= f_end);
    end

    // ---------------- checker / monitor ----------------
    bit         chk_en       = 1'b0;
    int         dut_xfer_cnt = 0;
    int         ferr_cnt     = 0;
    int         ovr_cnt      = 0;
    logic [7:0] last_xfer    = 8'd0;

    always @(negedge clk) begin
        if (chk_en) begin
            check_val("valid", out_valid, m_full);
            if (m_full) check_val("data", out_data, m_data);
            check_val("frame_err", frame_err, m_ferr);
            check_val("overrun", overrun, m_ovr);
            check_val("busy", busy, m_busy);
            check_val("err_ovr_excl", frame_err & overrun, 0);
            if (frame_err === 1'b1) ferr_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
            if (!rst && out_valid === 1'b1 && out_ready) begin
                last_xfer = out_data;
                dut_xfer_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_ready = 1'b0;

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit stop_good, input int hold,
                              input bit rdy_pulse);
        int s;
        @(posedge clk);
        #1;
        s       = cyc;
        rx_line = 1'b0;
        pend.push_back('{stop_cyc: s + STOP_OFS, good: stop_good, data: data});
        f_start = s;
        f_end   = stop_good ? s + STOP_OFS - 1 : s + 10 * CPB + SYNC_LAT + hold;
        if (rdy_pulse) begin
            fork
                begin
                    repeat (STOP_OFS - 1) @(posedge clk);
                    #1 out_ready = 1'b1;
                    @(posedge clk);
                    #1 out_ready = 1'b0;
                end
            join_none
        end
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx_line = data[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx_line = stop_good;
        repeat (CPB) @(posedge clk);
        #1;
        if (!stop_good) begin
            repeat (hold) @(posedge clk);
            #1;
        end
        rx_line = 1'b1;
    endtask

    task automatic send_glitch(input int len);
        @(posedge clk);
        #1;
        rx_line = 1'b0;
        f_start = cyc;
        f_end   = cyc + SYNC_LAT + HALF;
        repeat (len) @(posedge clk);
        #1 rx_line = 1'b1;
    endtask

    initial begin
        int o0;
        int f0;
        rst       = 1'b1;
        rx_line   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        idle(2);
        check_val("rst_data", out_data, 8'h00);
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(5);

        // Single byte, consumer always ready.
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        idle(20);
        check_val("a5_byte", last_xfer, 8'hA5);

        // Back-to-back bytes with the consumer stalled: second is dropped.
        out_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h3C, 1'b1, 0, 1'b0);
        send_frame(8'hC3, 1'b1, 0, 1'b0);
        idle(20);
        check_val("b2b_ovr_cnt", ovr_cnt - o0, 1);
        out_ready = 1'b1;
        idle(5);
        check_val("b2b_byte", last_xfer, 8'h3C);

        // Stop bit low followed by a long break.
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 2000, 1'b0);
        idle(20);
        check_val("brk_ferr_cnt", ferr_cnt - f0, 1);

        // Short low glitch on an idle line.
        send_glitch(30);
        idle(100);

        // Reset during bit 4 of 0xFF, then a clean byte.
        fork
            send_frame(8'hFF, 1'b1, 0, 1'b0);
            begin
                repeat (5 * CPB + HALF + 1) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                check_val("mid_rst_valid", out_valid, 1'b0);
                check_val("mid_rst_busy", busy, 1'b0);
                check_val("mid_rst_ferr", frame_err, 1'b0);
                check_val("mid_rst_ovr", overrun, 1'b0);
            end
        join
        idle(10);
        send_frame(8'h12, 1'b1, 0, 1'b0);
        idle(20);
        check_val("post_rst_byte", last_xfer, 8'h12);

        // Transfer coinciding with the stop sample of the next byte.
        out_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 0, 1'b0);
        idle(10);
        send_frame(8'h22, 1'b1, 0, 1'b1);
        idle(10);
        check_val("coinc_old_byte", last_xfer, 8'h11);
        check_val("coinc_valid", out_valid, 1'b1);
        check_val("coinc_ovr_cnt", ovr_cnt - o0, 0);
        out_ready = 1'b1;
        idle(5);
        check_val("coinc_new_byte", last_xfer, 8'h22);

        // Random frames, random stop validity, random consumer backpressure.
        rnd_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            logic [7:0] d;
            bit         g;
            d = 8'($urandom);
            g = ($urandom_range(0, 4) != 0);
            send_frame(d, g, int'($urandom_range(0, 100)), 1'b0);
            idle(int'($urandom_range(2, 40)));
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        idle(10);
        check_val("xfer_cnt", dut_xfer_cnt, m_xfer_cnt);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
